wb_bkram_responder: RTL and testbench
=====================================

Name: wb_bkram_responder

Overview:
- Pipelined Wishbone B4 block-RAM responder; the slave end of the data-cache and memory-unit bus requests.
- Serves the cachable BKRAM region; the bus interconnect has already decoded the region, so this block sees only in-region strobes.
- Single-cycle issue with no stall; fixed read/write latency of 1 or 2 clocks.
- Byte-lane writes; transfer aborts when CYC drops.

Parameters:
- LGMEMSZ, 15, log2 of memory size in bytes; word count = 2^(LGMEMSZ-2).
- DW, 32, data width in bits (fixed 32; SEL is DW/8 = 4).
- EXTRADELAY, 0, 0 gives ack 1 clock after the request; 1 gives ack 2 clocks after (registered request stage).
- OPT_ROM, 0, 1 ignores writes but still acks them.

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  synchronous active-high reset
- i_wb_cyc  in  1  bus cycle active
- i_wb_stb  in  1  request strobe
- i_wb_we  in  1  1 = write, 0 = read
- i_wb_addr  in  LGMEMSZ-2  word address
- i_wb_data  in  DW  write data
- i_wb_sel  in  DW/8  byte enables; bit 3 is [31:24]
- o_wb_stall  out  1  always 0
- o_wb_ack  out  1  one ack per accepted request
- o_wb_data  out  DW  read data, valid when o_wb_ack is high

Behaviour:
- Reset and abort:
  - On i_reset: o_wb_ack=0, o_wb_data=0, and all pipeline valid bits cleared.
  - Memory contents are not reset.
- Request acceptance:
  - A request is accepted when i_wb_cyc && i_wb_stb; o_wb_stall is tied to 0.
  - A strobe without cyc is ignored: no ack, no write.
- EXTRADELAY=0:
  - Cycle N: request accepted.
  - Cycle N: a write with we=1 commits each byte lane whose sel bit is set; unselected lanes keep their old value.
  - Cycle N+1: o_wb_ack=1.
  - Cycle N+1: o_wb_data holds mem[addr] for reads; for writes it is don't-care but deterministic.
- EXTRADELAY=1:
  - Request, address, data, sel and we are registered in cycle N.
  - Memory access and write commit happen in cycle N+1.
  - Cycle N+2: o_wb_ack=1.
- Pipelining:
  - Back-to-back strobes give back-to-back acks in request order: k strobes give exactly k acks.
  - Read-after-write to the same address in consecutive cycles returns the new data, byte-merged per sel.
  - Write-after-read in consecutive cycles: the read returns the old data.
- CYC drop (abort):
  - If i_wb_cyc=0 in any cycle, all in-flight valid bits clear and o_wb_ack=0 from the next cycle.
  - A request accepted before the drop keeps its memory write, including the EXTRADELAY=1 stage-1 write.
  - Only its ack is suppressed.
- OPT_ROM=1:
  - Writes are acked with normal latency; memory is unchanged.
- Reset mid-transfer:
  - Same as the CYC drop.
  - A write in the registered stage (EXTRADELAY=1) is discarded and is not committed.
- Address wrap:
  - Address is used modulo 2^(LGMEMSZ-2); there is no error output.
- o_wb_data:
  - Updates only on a read access.
  - Holds its value otherwise, so a bus monitor sees stable data.

Test Plan:
- Single write then read, EXTRADELAY=0: write 0xDEADBEEF to addr 0x10 with sel=4'hF; read addr 0x10 in the next cycle.
  -> Acks in cycles 1 and 2; read data = 0xDEADBEEF.
- Byte lanes: preload addr 5 with 0x11223344; write 0xAABBCCDD with sel=4'b0101; read addr 5.
  -> 0x11BB33DD.
- Pipelined burst, EXTRADELAY=1: 8 consecutive reads of addrs 0..7, preloaded with the value 0x100+i.
  -> 8 consecutive acks starting 2 cycles after the first strobe, data 0x100..0x107 in order, o_wb_stall always 0.
- Abort: issue 3 reads, then drop cyc one cycle after the last strobe.
  -> At most the acks already due before the drop; zero acks after it.
  -> Next cycle: a fresh read of one address acks exactly once.
- Reset mid-operation, EXTRADELAY=1: a write to addr 3 is in the registered stage when i_reset is asserted.
  -> o_wb_ack=0 and o_wb_data=0 next cycle; addr 3 keeps its prior value.
- OPT_ROM=1 and wrap: write 0x55 to addr 2^(LGMEMSZ-2)+1, then read addr 1.
  -> The write is acked; the read returns the original contents of addr 1.

Source files
------------

// File: rtl/wb_bkram_responder.sv
// Pipelined Wishbone B4 block-RAM responder with byte-lane writes and a fixed
// 1- or 2-clock ack latency. One 8-bit RAM column per byte lane.

module wb_bkram_lane #(
  parameter int AW = 13
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);
  logic [7:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;

  // Read data only moves on a read access so a bus monitor sees it held.
  always_ff @(posedge clk)
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[addr];
endmodule

module wb_bkram_responder #(
  parameter int LGMEMSZ    = 15,
  parameter int DW         = 32,
  parameter int EXTRADELAY = 0,
  parameter int OPT_ROM    = 0
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_wb_cyc,
  input  logic                 i_wb_stb,
  input  logic                 i_wb_we,
  input  logic [LGMEMSZ-3:0]   i_wb_addr,
  input  logic [DW-1:0]        i_wb_data,
  input  logic [DW/8-1:0]      i_wb_sel,
  output logic                 o_wb_stall,
  output logic                 o_wb_ack,
  output logic [DW-1:0]        o_wb_data
);
  localparam int AW        = LGMEMSZ - 2;
  localparam int NUM_LANES = DW / 8;
  localparam int STAGES    = EXTRADELAY + 1;

  logic                 req;
  logic                 acc_stb, acc_we;
  logic [AW-1:0]        acc_addr;
  logic [DW-1:0]        acc_data;
  logic [NUM_LANES-1:0] acc_sel;
  logic                 wr_en, rd_en;
  logic [STAGES:1]      vld_pipe;

  assign req        = i_wb_cyc & i_wb_stb;
  assign o_wb_stall = 1'b0;

  generate
    if (EXTRADELAY != 0) begin : g_reg
      logic                 r_stb, r_we;
      logic [AW-1:0]        r_addr;
      logic [DW-1:0]        r_data;
      logic [NUM_LANES-1:0] r_sel;

      // The registered request survives a CYC drop so its write still lands;
      // only reset discards it.
      always_ff @(posedge i_clk) begin
        if (i_reset) r_stb <= 1'b0;
        else         r_stb <= req;
        r_we   <= i_wb_we;
        r_addr <= i_wb_addr;
        r_data <= i_wb_data;
        r_sel  <= i_wb_sel;
      end

      assign acc_stb  = r_stb;
      assign acc_we   = r_we;
      assign acc_addr = r_addr;
      assign acc_data = r_data;
      assign acc_sel  = r_sel;
    end else begin : g_comb
      assign acc_stb  = req;
      assign acc_we   = i_wb_we;
      assign acc_addr = i_wb_addr;
      assign acc_data = i_wb_data;
      assign acc_sel  = i_wb_sel;
    end
  endgenerate

  assign wr_en = acc_stb & acc_we & ~i_reset & (OPT_ROM == 0);
  assign rd_en = acc_stb & ~acc_we;

  generate
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
      wb_bkram_lane #(.AW(AW)) u_lane (
        .clk   (i_clk),
        .rst   (i_reset),
        .we    (wr_en & acc_sel[l]),
        .re    (rd_en),
        .addr  (acc_addr),
        .wdata (acc_data[8*l +: 8]),
        .rdata (o_wb_data[8*l +: 8])
      );
    end
  endgenerate

  // Ack tracking only: dropping CYC kills every in-flight ack.
  always_ff @(posedge i_clk) begin
    if (i_reset || !i_wb_cyc) begin
      vld_pipe <= '0;
    end else begin
      vld_pipe[1] <= req;
      for (int i = 2; i <= STAGES; i++)
        vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  assign o_wb_ack = vld_pipe[STAGES];
endmodule

// File: tb/tb_wb_bkram_responder.sv
// Directed bench: u0 = 1-clock RAM, u1 = 2-clock RAM, u2 = 1-clock ROM, all
// driven by the same bus so each scenario checks the relevant latency.

module tb_wb_bkram_responder;
  logic        clk = 1'b0;
  logic        rst, cyc, stb, we;
  logic [12:0] addr;
  logic [31:0] wdata;
  logic [3:0]  sel;
  logic [2:0]  ack, stall;
  logic [31:0] dat [3];
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  wb_bkram_responder #(.LGMEMSZ(15), .DW(32), .EXTRADELAY(0), .OPT_ROM(0)) u0 (
    .i_clk(clk), .i_reset(rst), .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
    .i_wb_addr(addr), .i_wb_data(wdata), .i_wb_sel(sel),
    .o_wb_stall(stall[0]), .o_wb_ack(ack[0]), .o_wb_data(dat[0]));

  wb_bkram_responder #(.LGMEMSZ(15), .DW(32), .EXTRADELAY(1), .OPT_ROM(0)) u1 (
    .i_clk(clk), .i_reset(rst), .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
    .i_wb_addr(addr), .i_wb_data(wdata), .i_wb_sel(sel),
    .o_wb_stall(stall[1]), .o_wb_ack(ack[1]), .o_wb_data(dat[1]));

  wb_bkram_responder #(.LGMEMSZ(15), .DW(32), .EXTRADELAY(0), .OPT_ROM(1)) u2 (
    .i_clk(clk), .i_reset(rst), .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
    .i_wb_addr(addr), .i_wb_data(wdata), .i_wb_sel(sel),
    .o_wb_stall(stall[2]), .o_wb_ack(ack[2]), .o_wb_data(dat[2]));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic c, input logic s, input logic w,
                     input logic [12:0] a, input logic [31:0] d, input logic [3:0] sl);
    cyc = c; stb = s; we = w; addr = a; wdata = d; sel = sl;
  endtask

  task automatic idle;
    drv(1'b1, 1'b0, 1'b0, 13'h0, 32'h0, 4'h0);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drv(1'b0, 1'b0, 1'b0, 13'h0, 32'h0, 4'h0);
    tick; tick;
    for (int i = 0; i < 3; i++) begin
      n_vec++; if (ack[i] !== 1'b0) begin n_err++; $display("FAIL reset_ack u%0d got %b want 0", i, ack[i]); end
      n_vec++; if (dat[i] !== 32'h0) begin n_err++; $display("FAIL reset_data u%0d got %h want 0", i, dat[i]); end
      n_vec++; if (stall[i] !== 1'b0) begin n_err++; $display("FAIL reset_stall u%0d got %b want 0", i, stall[i]); end
    end
    rst = 1'b0;
    tick;
  endtask

  task automatic test_write_read;
    drv(1'b1, 1'b1, 1'b1, 13'h10, 32'hDEADBEEF, 4'hF); tick;
    n_vec++; if (ack[0] !== 1'b1) begin n_err++; $display("FAIL wr_ack u0 got %b want 1", ack[0]); end
    drv(1'b1, 1'b1, 1'b0, 13'h10, 32'h0, 4'h0); tick;
    n_vec++; if (ack[0] !== 1'b1) begin n_err++; $display("FAIL rd_ack u0 got %b want 1", ack[0]); end
    n_vec++; if (dat[0] !== 32'hDEADBEEF) begin n_err++; $display("FAIL rd_data u0 got %h want deadbeef", dat[0]); end
    n_vec++; if (ack[1] !== 1'b1) begin n_err++; $display("FAIL wr_ack u1 got %b want 1", ack[1]); end
    // strobe with cyc low: must neither ack nor write
    drv(1'b0, 1'b1, 1'b1, 13'h10, 32'h0, 4'hF); tick;
    n_vec++; if (ack[0] !== 1'b0) begin n_err++; $display("FAIL nocyc_ack u0 got %b want 0", ack[0]); end
    n_vec++; if (ack[1] !== 1'b0) begin n_err++; $display("FAIL nocyc_ack u1 got %b want 0", ack[1]); end
    drv(1'b1, 1'b1, 1'b0, 13'h10, 32'h0, 4'h0); tick;
    n_vec++; if (ack[0] !== 1'b1) begin n_err++; $display("FAIL reread_ack u0 got %b want 1", ack[0]); end
    n_vec++; if (dat[0] !== 32'hDEADBEEF) begin n_err++; $display("FAIL nocyc_nowrite u0 got %h want deadbeef", dat[0]); end
    idle; tick;
    n_vec++; if (dat[1] !== 32'hDEADBEEF) begin n_err++; $display("FAIL rd_data u1 got %h want deadbeef", dat[1]); end
    tick;
  endtask

  task automatic test_byte_lanes;
    drv(1'b1, 1'b1, 1'b1, 13'h5, 32'h11223344, 4'hF); tick;
    drv(1'b1, 1'b1, 1'b1, 13'h5, 32'hAABBCCDD, 4'b0101); tick;
    drv(1'b1, 1'b1, 1'b0, 13'h5, 32'h0, 4'h0); tick;
    n_vec++; if (dat[0] !== 32'h11BB33DD) begin n_err++; $display("FAIL bytes u0 got %h want 11bb33dd", dat[0]); end
    // write right behind the read: read keeps the old value, data held
    drv(1'b1, 1'b1, 1'b1, 13'h5, 32'h0, 4'hF); tick;
    n_vec++; if (dat[1] !== 32'h11BB33DD) begin n_err++; $display("FAIL bytes u1 got %h want 11bb33dd", dat[1]); end
    n_vec++; if (dat[0] !== 32'h11BB33DD) begin n_err++; $display("FAIL hold_on_write u0 got %h want 11bb33dd", dat[0]); end
    drv(1'b1, 1'b1, 1'b0, 13'h5, 32'h0, 4'h0); tick;
    n_vec++; if (dat[0] !== 32'h0) begin n_err++; $display("FAIL war_new u0 got %h want 0", dat[0]); end
    idle; tick;
    n_vec++; if (dat[1] !== 32'h0) begin n_err++; $display("FAIL war_new u1 got %h want 0", dat[1]); end
    tick;
  endtask

  task automatic test_burst;
    int n0, n1, s;
    logic e0, e1;
    for (int i = 0; i < 8; i++) begin
      drv(1'b1, 1'b1, 1'b1, 13'(i), 32'h100 + 32'(i), 4'hF); tick;
    end
    idle; tick; tick;
    n0 = 0; n1 = 0;
    for (int k = 0; k < 11; k++) begin
      if (k < 8) drv(1'b1, 1'b1, 1'b0, 13'(k), 32'h0, 4'h0);
      else       idle;
      tick;
      s  = k + 1;
      e0 = (s >= 1 && s <= 8);
      e1 = (s >= 2 && s <= 9);
      n0 += int'(ack[0]); n1 += int'(ack[1]);
      n_vec++; if (ack[1] !== e1) begin n_err++; $display("FAIL burst_ack u1 cyc%0d got %b want %b", s, ack[1], e1); end
      n_vec++; if (ack[0] !== e0) begin n_err++; $display("FAIL burst_ack u0 cyc%0d got %b want %b", s, ack[0], e0); end
      n_vec++; if (stall[1] !== 1'b0) begin n_err++; $display("FAIL burst_stall u1 cyc%0d got %b want 0", s, stall[1]); end
      if (e1) begin
        n_vec++;
        if (dat[1] !== 32'h100 + 32'(s - 2)) begin
          n_err++; $display("FAIL burst_data u1 cyc%0d got %h want %h", s, dat[1], 32'h100 + 32'(s - 2));
        end
      end
    end
    n_vec++; if (n0 !== 8) begin n_err++; $display("FAIL burst_count u0 got %0d want 8", n0); end
    n_vec++; if (n1 !== 8) begin n_err++; $display("FAIL burst_count u1 got %0d want 8", n1); end
  endtask

  task automatic run_abort(input bit gap);
    int n0, n1;
    n0 = 0; n1 = 0;
    for (int k = 0; k < 3; k++) begin
      drv(1'b1, 1'b1, 1'b0, 13'(k), 32'h0, 4'h0); tick;
      n0 += int'(ack[0]); n1 += int'(ack[1]);
    end
    if (gap) begin
      idle; tick;
      n0 += int'(ack[0]); n1 += int'(ack[1]);
    end
    drv(1'b0, 1'b0, 1'b0, 13'h0, 32'h0, 4'h0);
    for (int k = 0; k < 2; k++) begin
      tick;
      n_vec++; if (ack[0] !== 1'b0) begin n_err++; $display("FAIL abort_after u0 gap%0d got %b want 0", gap, ack[0]); end
      n_vec++; if (ack[1] !== 1'b0) begin n_err++; $display("FAIL abort_after u1 gap%0d got %b want 0", gap, ack[1]); end
    end
    n_vec++; if (n0 !== 3) begin n_err++; $display("FAIL abort_count u0 gap%0d got %0d want 3", gap, n0); end
    n_vec++; if (n1 !== (gap ? 3 : 2)) begin n_err++; $display("FAIL abort_count u1 gap%0d got %0d want %0d", gap, n1, gap ? 3 : 2); end
    drv(1'b1, 1'b1, 1'b0, 13'h7, 32'h0, 4'h0); tick;
    n_vec++; if (ack[0] !== 1'b1) begin n_err++; $display("FAIL fresh_ack u0 got %b want 1", ack[0]); end
    n_vec++; if (dat[0] !== 32'h107) begin n_err++; $display("FAIL fresh_data u0 got %h want 107", dat[0]); end
    idle; tick;
    n_vec++; if (ack[1] !== 1'b1) begin n_err++; $display("FAIL fresh_ack u1 got %b want 1", ack[1]); end
    n_vec++; if (dat[1] !== 32'h107) begin n_err++; $display("FAIL fresh_data u1 got %h want 107", dat[1]); end
    n_vec++; if (ack[0] !== 1'b0) begin n_err++; $display("FAIL fresh_once u0 got %b want 0", ack[0]); end
    tick;
    n_vec++; if (ack[1] !== 1'b0) begin n_err++; $display("FAIL fresh_once u1 got %b want 0", ack[1]); end
    drv(1'b0, 1'b0, 1'b0, 13'h0, 32'h0, 4'h0); tick;
  endtask

  task automatic test_abort;
    run_abort(1'b1);
    run_abort(1'b0);
    // registered write must still land although its ack is dropped
    drv(1'b1, 1'b1, 1'b1, 13'h9, 32'h99, 4'hF); tick;
    drv(1'b0, 1'b0, 1'b0, 13'h0, 32'h0, 4'h0); tick;
    n_vec++; if (ack[1] !== 1'b0) begin n_err++; $display("FAIL abort_wr_ack u1 got %b want 0", ack[1]); end
    tick;
    drv(1'b1, 1'b1, 1'b0, 13'h9, 32'h0, 4'h0); tick;
    idle; tick;
    n_vec++; if (dat[1] !== 32'h99) begin n_err++; $display("FAIL abort_wr_kept u1 got %h want 99", dat[1]); end
    n_vec++; if (dat[0] !== 32'h99) begin n_err++; $display("FAIL abort_wr_kept u0 got %h want 99", dat[0]); end
    tick;
  endtask

  task automatic test_reset_mid;
    drv(1'b1, 1'b1, 1'b1, 13'h3, 32'h33333333, 4'hF); tick;
    idle; tick; tick;
    drv(1'b1, 1'b1, 1'b1, 13'h3, 32'hCAFEF00D, 4'hF); tick;
    rst = 1'b1;
    drv(1'b0, 1'b0, 1'b0, 13'h0, 32'h0, 4'h0); tick;
    n_vec++; if (ack[1] !== 1'b0) begin n_err++; $display("FAIL rstmid_ack u1 got %b want 0", ack[1]); end
    n_vec++; if (dat[1] !== 32'h0) begin n_err++; $display("FAIL rstmid_data u1 got %h want 0", dat[1]); end
    n_vec++; if (dat[0] !== 32'h0) begin n_err++; $display("FAIL rstmid_data u0 got %h want 0", dat[0]); end
    rst = 1'b0; tick;
    drv(1'b1, 1'b1, 1'b0, 13'h3, 32'h0, 4'h0); tick;
    n_vec++; if (dat[0] !== 32'hCAFEF00D) begin n_err++; $display("FAIL rstmid_u0_write got %h want cafef00d", dat[0]); end
    idle; tick;
    n_vec++; if (dat[1] !== 32'h33333333) begin n_err++; $display("FAIL rstmid_discard u1 got %h want 33333333", dat[1]); end
    tick;
  endtask

  task automatic test_rom_wrap;
    logic [13:0] wa;
    wa = 14'h2001;
    drv(1'b1, 1'b1, 1'b1, wa[12:0], 32'h55, 4'hF); tick;
    n_vec++; if (ack[2] !== 1'b1) begin n_err++; $display("FAIL rom_wr_ack u2 got %b want 1", ack[2]); end
    n_vec++; if (ack[0] !== 1'b1) begin n_err++; $display("FAIL wrap_wr_ack u0 got %b want 1", ack[0]); end
    drv(1'b1, 1'b1, 1'b0, 13'h1, 32'h0, 4'h0); tick;
    n_vec++; if (ack[2] !== 1'b1) begin n_err++; $display("FAIL rom_rd_ack u2 got %b want 1", ack[2]); end
    n_vec++; if (dat[0] !== 32'h55) begin n_err++; $display("FAIL wrap_data u0 got %h want 55", dat[0]); end
    n_vec++; if (dat[2] === 32'h55) begin n_err++; $display("FAIL rom_unchanged u2 got %h want not 55", dat[2]); end
    idle; tick;
  endtask

  initial begin
    rst = 1'b1;
    drv(1'b0, 1'b0, 1'b0, 13'h0, 32'h0, 4'h0);
    test_reset;
    test_write_read;
    test_byte_lanes;
    test_burst;
    test_abort;
    test_reset_mid;
    test_rom_wrap;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
